// File: rtl/spi_ram_master_ctrl.sv
// Host-side sequencer: expands one byte read/write request into 10-bit SPI frames to the RAM slave.
// Optional build macro SPI_WR_VERIFY_EN: each write is followed by a readback and compare.
module spi_ram_master_ctrl #(
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rd,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_resp_valid,
    output logic [7:0] o_resp_rdata,
    output logic       o_resp_err,
    output logic       o_ss_n,
    output logic       o_mosi,
    input  logic       i_miso
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TURN  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [7:0] C_GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [7:0] C_TURN_LAST = 8'(RD_LAT - 1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_frm;
    logic [9:0] r_sreg;
    logic [7:0] r_rx;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    logic       w_accept;
    logic       w_rd_frm;
    logic       w_last_frm;
    logic [9:0] w_frame;

    assign o_req_ready  = (r_state == ST_IDLE) && !i_rst;
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_rd_frm     = (r_frm == 2'd3);
    assign o_resp_valid = (r_state == ST_DONE);
    assign o_resp_rdata = r_rdata;
    assign o_ss_n       = !((r_state == ST_START) || (r_state == ST_SHIFT) ||
                            (r_state == ST_TURN)  || (r_state == ST_RECV));
    assign o_mosi       = (r_state == ST_SHIFT) ? r_sreg[9] : 1'b0;

    // Frame index doubles as the command code: writes run 0..1, reads 2..3.
    always_comb begin
        case (r_frm)
            2'd0:    w_frame = {2'b00, r_addr};
            2'd1:    w_frame = {2'b01, r_wdata};
            2'd2:    w_frame = {2'b10, r_addr};
            default: w_frame = {2'b11, 8'h00};
        endcase
    end

`ifdef SPI_WR_VERIFY_EN
    logic r_is_wr;
    logic r_err;

    assign w_last_frm = w_rd_frm;
    assign o_resp_err = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_wr <= !i_req_rd;
            end
            if ((r_state == ST_GAP) && (r_cnt == C_GAP_LAST) && w_last_frm) begin
                r_err <= r_is_wr && (r_rx != r_wdata);
            end
        end
    end
`else
    assign w_last_frm = r_frm[0];
    assign o_resp_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_frm   <= 2'd0;
            r_sreg  <= 10'd0;
            r_rx    <= 8'd0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
            r_rdata <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_frm   <= i_req_rd ? 2'd2 : 2'd0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_sreg  <= w_frame;
                    r_cnt   <= 8'd0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_sreg <= {r_sreg[8:0], 1'b0};
                    if (r_cnt == 8'd9) begin
                        r_cnt <= 8'd0;
                        if (w_rd_frm) begin
                            r_state <= (RD_LAT == 0) ? ST_RECV : ST_TURN;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_TURN: begin
                    if (r_cnt == C_TURN_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_RECV;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RECV: begin
                    r_rx <= {r_rx[6:0], i_miso};
                    if (r_cnt == 8'd7) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt <= 8'd0;
                        if (w_last_frm) begin
                            if (w_rd_frm) begin
                                r_rdata <= r_rx;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            r_frm   <= r_frm + 2'd1;
                            r_state <= ST_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
